// File: rtl/sw_result_serializer.sv
// sw_result_serializer
//  Buffers Smith-Waterman alignment results (score, column, row) in a small FIFO
//  and emits each one as a fixed-length, MSB-first byte frame on a valid/ready
//  byte stream. This lets the core start the next alignment while the previous
//  result is still being sent.
// Ports
//  avm_clk, avm_rst                      clock, synchronous active-high reset
//  i_valid / o_ready                     result handshake from the core
//  i_alignment_score, i_column, i_row    result payload
//  o_byte_valid / o_byte / i_byte_ready  outgoing byte stream
//  o_frame_done                          one-cycle pulse after the last byte is consumed
module sw_result_serializer #(
  parameter int unsigned SCORE_BW    = 10,
  parameter int unsigned POS_BW      = 8,
  parameter int unsigned FRAME_BYTES = 32,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SCORE_BW-1:0] i_alignment_score,
  input  logic [POS_BW-1:0]   i_column,
  input  logic [POS_BW-1:0]   i_row,
  output logic                o_byte_valid,
  output logic [7:0]          o_byte,
  input  logic                i_byte_ready,
  output logic                o_frame_done
);

  localparam int unsigned FieldW = 16;
  localparam int unsigned HdrW   = 3 * FieldW;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned BcW    = $clog2(FRAME_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Parameter sanity checks at elaboration
  if (FRAME_BYTES < 6) begin : g_bad_frame_bytes
    $error("sw_result_serializer: FRAME_BYTES must be >= 6");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("sw_result_serializer: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (SCORE_BW > FieldW || POS_BW > FieldW) begin : g_bad_field_width
    $error("sw_result_serializer: SCORE_BW and POS_BW must be <= 16");
  end

  // Frame header as it leaves the wire: score, column, row, 16 bits each
  typedef struct packed {
    logic [FieldW-1:0] score;
    logic [FieldW-1:0] column;
    logic [FieldW-1:0] row;
  } result_t;

  result_t             mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [1:0]          state_q, state_d;
  logic [BcW-1:0]      bcnt_q, bcnt_d;
  logic [HdrW-1:0]     shift_q, shift_d;
  logic                byte_valid_q, byte_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                push_c;
  logic                pop_c;
  result_t             entry_c;

  // Ready depends only on registered occupancy and reset, never on i_valid
  assign o_ready = !avm_rst && (count_q != CntW'(FIFO_DEPTH));
  assign push_c  = i_valid && o_ready;

  // Widen the payload once at push so later input changes cannot reach the frame
  always_comb begin
    entry_c.score  = FieldW'($signed(i_alignment_score));
    entry_c.column = FieldW'(i_column);
    entry_c.row    = FieldW'(i_row);
  end

  // FIFO storage; entries are only meaningful while counted, so no reset
  always_ff @(posedge avm_clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= entry_c;
    end
  end

  // Next-state, FIFO bookkeeping and output decode
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    pop_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          shift_d      = mem_q[rd_ptr_q];
          pop_c        = 1'b1;
          bcnt_d       = '0;
          byte_valid_d = 1'b1;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        byte_valid_d = 1'b1;
        if (i_byte_ready) begin
          // Zeros shift in behind the header, giving the padding bytes for free
          shift_d = {shift_q[HdrW-9:0], 8'h00};
          bcnt_d  = bcnt_q + BcW'(1);
          if (bcnt_q == BcW'(FRAME_BYTES - 1)) begin
            byte_valid_d = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = push_c ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CntW'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State and control registers
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_byte_valid = byte_valid_q;
  assign o_byte       = shift_q[HdrW-1 -: 8];
  assign o_frame_done = frame_done_q;

endmodule
